// File: rtl/keyscan_pkg.sv
// Shared types, widths and helpers for the 8x8 matrix key scanner.
package keyscan_pkg;

    localparam int unsigned N_LINES    = 8;
    localparam int unsigned IDX_W      = 3;
    localparam int unsigned KEY_CODE_W = 6;
    localparam int unsigned CNT_W      = 4;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HOLD     = 2'd2,
        RELEASE  = 2'd3
    } ks_state_e;

    // Active-low column pattern with only bit idx pulled low.
    function automatic logic [N_LINES-1:0] onehot_low(input logic [IDX_W-1:0] idx);
        logic [N_LINES-1:0] pat;
        pat      = '1;
        pat[idx] = 1'b0;
        return pat;
    endfunction

    // Index of the lowest-numbered row that reads low.
    function automatic logic [IDX_W-1:0] lowest_low(input logic [N_LINES-1:0] rows);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = int'(N_LINES) - 1; i >= 0; i--) begin
            if (!rows[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs; idles at all-ones.
module sync_2ff #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            meta_q <= '1;
            sync_q <= '1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/matrix_key_scanner.sv
// Scans an 8x8 key matrix one column per tick, debounces the first key found
// and hands its {col,row} code to the consumer on a valid/ready handshake.
module matrix_key_scanner #(
    parameter int unsigned DEBOUNCE_TICKS = 4,
    parameter int unsigned N_LINES        = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           tick,
    input  logic [N_LINES-1:0]             row_sense,
    output logic [N_LINES-1:0]             col_drive,
    output logic                           key_valid,
    output logic [keyscan_pkg::KEY_CODE_W-1:0] key_code,
    input  logic                           key_ready,
    output logic                           key_held,
    output logic                           overflow
);

    import keyscan_pkg::*;

    localparam logic [CNT_W-1:0] TICKS_TARGET = CNT_W'(DEBOUNCE_TICKS);

    ks_state_e              state_q, state_d;
    logic [IDX_W-1:0]       col_q, col_d;
    logic [IDX_W-1:0]       row_q, row_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [N_LINES-1:0]     col_drive_q;
    logic                   key_valid_q, key_valid_d;
    logic [KEY_CODE_W-1:0]  key_code_q, key_code_d;
    logic                   key_held_q, key_held_d;
    logic                   overflow_q, overflow_d;

    logic [N_LINES-1:0]     rows_s;
    logic                   any_low_c;
    logic                   row_low_c;
    logic [CNT_W-1:0]       cnt_inc_c;
    logic                   accept_c;

    sync_2ff #(.WIDTH(N_LINES)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (row_sense),
        .q_o   (rows_s)
    );

    assign any_low_c = ~&rows_s;
    assign row_low_c = ~rows_s[row_q];
    assign cnt_inc_c = cnt_q + CNT_W'(1);

    // Scan / debounce / hold / release sequencing, evaluated only on ticks.
    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        row_d    = row_q;
        cnt_d    = cnt_q;
        accept_c = 1'b0;
        if (tick) begin
            case (state_q)
                SCAN: begin
                    if (any_low_c) begin
                        row_d = lowest_low(rows_s);
                        cnt_d = CNT_W'(1);
                        if (TICKS_TARGET == CNT_W'(1)) begin
                            state_d  = HOLD;
                            accept_c = 1'b1;
                        end else begin
                            state_d = DEBOUNCE;
                        end
                    end else begin
                        col_d = col_q + IDX_W'(1);
                    end
                end
                DEBOUNCE: begin
                    if (row_low_c) begin
                        cnt_d = cnt_inc_c;
                        if (cnt_inc_c == TICKS_TARGET) begin
                            state_d  = HOLD;
                            accept_c = 1'b1;
                        end
                    end else begin
                        state_d = SCAN;
                        col_d   = col_q + IDX_W'(1);
                    end
                end
                HOLD: begin
                    if (!row_low_c) begin
                        cnt_d = CNT_W'(1);
                        if (TICKS_TARGET == CNT_W'(1)) begin
                            state_d = SCAN;
                            col_d   = col_q + IDX_W'(1);
                        end else begin
                            state_d = RELEASE;
                        end
                    end
                end
                RELEASE: begin
                    if (!row_low_c) begin
                        cnt_d = cnt_inc_c;
                        if (cnt_inc_c == TICKS_TARGET) begin
                            state_d = SCAN;
                            col_d   = col_q + IDX_W'(1);
                        end
                    end else begin
                        state_d = HOLD;
                    end
                end
                default: state_d = SCAN;
            endcase
        end
    end

    // Handshake: a consume and a new press in the same cycle hand over cleanly.
    always_comb begin
        key_valid_d = key_valid_q;
        key_code_d  = key_code_q;
        overflow_d  = 1'b0;
        key_held_d  = (state_d == HOLD) || (state_d == RELEASE);
        if (key_valid_q && key_ready) key_valid_d = 1'b0;
        if (accept_c) begin
            if (!key_valid_q || key_ready) begin
                key_valid_d = 1'b1;
                key_code_d  = {col_q, row_d};
            end else begin
                overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= SCAN;
            col_q       <= '0;
            row_q       <= '0;
            cnt_q       <= '0;
            col_drive_q <= onehot_low(IDX_W'(0));
            key_valid_q <= 1'b0;
            key_code_q  <= '0;
            key_held_q  <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            cnt_q       <= cnt_d;
            col_drive_q <= onehot_low(col_d);
            key_valid_q <= key_valid_d;
            key_code_q  <= key_code_d;
            key_held_q  <= key_held_d;
            overflow_q  <= overflow_d;
        end
    end

    assign col_drive = col_drive_q;
    assign key_valid = key_valid_q;
    assign key_code  = key_code_q;
    assign key_held  = key_held_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_matrix_key_scanner.sv
// Directed bench for matrix_key_scanner: a key-matrix model drives row_sense
// from col_drive; a tick table plus hand sequences cover the corner cases.
module tb_matrix_key_scanner;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick;
    logic [7:0] row_sense;
    logic [7:0] col_drive;
    logic       key_valid;
    logic [5:0] key_code;
    logic       key_ready;
    logic       key_held;
    logic       overflow;

    logic [63:0] keys;
    int          errors = 0;
    int          checks = 0;
    int          events = 0;
    int          ovf_pulses = 0;
    logic [5:0]  last_code = 6'h3F;

    typedef struct {
        int         kc;
        int         kr;
        logic       rdy;
        logic [7:0] col;
        logic       vld;
        logic       hld;
    } vec_t;

    vec_t vecs[32];

    always #5 clk = ~clk;

    matrix_key_scanner #(.DEBOUNCE_TICKS(4), .N_LINES(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .tick      (tick),
        .row_sense (row_sense),
        .col_drive (col_drive),
        .key_valid (key_valid),
        .key_code  (key_code),
        .key_ready (key_ready),
        .key_held  (key_held),
        .overflow  (overflow)
    );

    // Pressed key at (c,r) shorts column c to row r; both active-low.
    always_comb begin
        row_sense = 8'hFF;
        for (int c = 0; c < 8; c++) begin
            if (!col_drive[c]) row_sense = row_sense & ~keys[c*8 +: 8];
        end
    end

    // Observe the handshake just before each rising edge.
    always @(negedge clk) begin
        #4;
        if (key_valid && key_ready) begin
            events++;
            last_code = key_code;
        end
        if (overflow) ovf_pulses++;
    end

    initial begin
        #500000;
        $display("FAIL timeout: bench did not finish in time");
        $fatal(1);
    end

    function automatic vec_t mk(input int kc, input int kr, input logic rdy,
                                input logic [7:0] col, input logic vld, input logic hld);
        vec_t v;
        v.kc = kc; v.kr = kr; v.rdy = rdy; v.col = col; v.vld = vld; v.hld = hld;
        return v;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_tick(input logic rdy_pulse);
        logic saved;
        saved = key_ready;
        repeat (3) @(negedge clk);
        tick = 1'b1;
        if (rdy_pulse) key_ready = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        key_ready = saved;
        #2;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) do_tick(1'b0);
    endtask

    task automatic goto_col(input int idx);
        logic [7:0] tgt;
        tgt = 8'hFF;
        tgt[idx] = 1'b0;
        for (int n = 0; n < 8 && col_drive !== tgt; n++) do_tick(1'b0);
        check("goto_col", col_drive, tgt);
    endtask

    task automatic set_key(input int c, input int r, input logic v);
        keys[c*8 + r] = v;
    endtask

    initial begin
        logic [7:0] pat;
        reset = 1'b0; tick = 1'b0; key_ready = 1'b1; keys = '0;

        // Table: 16 idle ticks, then a clean press of (3,5) held 12 ticks and released.
        for (int i = 0; i < 16; i++) begin
            pat = 8'hFF;
            pat[(i + 1) % 8] = 1'b0;
            vecs[i] = mk(-1, 0, 1'b1, pat, 1'b0, 1'b0);
        end
        vecs[16] = mk(3, 5, 1'b1, 8'hFD, 1'b0, 1'b0);
        vecs[17] = mk(3, 5, 1'b1, 8'hFB, 1'b0, 1'b0);
        vecs[18] = mk(3, 5, 1'b1, 8'hF7, 1'b0, 1'b0);
        vecs[19] = mk(3, 5, 1'b1, 8'hF7, 1'b0, 1'b0);
        vecs[20] = mk(3, 5, 1'b1, 8'hF7, 1'b0, 1'b0);
        vecs[21] = mk(3, 5, 1'b1, 8'hF7, 1'b0, 1'b0);
        vecs[22] = mk(3, 5, 1'b1, 8'hF7, 1'b1, 1'b1);
        for (int i = 23; i < 28; i++) vecs[i] = mk(3, 5, 1'b1, 8'hF7, 1'b0, 1'b1);
        vecs[28] = mk(-1, 0, 1'b1, 8'hF7, 1'b0, 1'b1);
        vecs[29] = mk(-1, 0, 1'b1, 8'hF7, 1'b0, 1'b1);
        vecs[30] = mk(-1, 0, 1'b1, 8'hF7, 1'b0, 1'b1);
        vecs[31] = mk(-1, 0, 1'b1, 8'hEF, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        #2;
        check("rst_col_drive", col_drive, 8'hFE);
        check("rst_key_valid", 8'(key_valid), 8'h0);
        check("rst_key_code", 8'(key_code), 8'h0);
        check("rst_key_held", 8'(key_held), 8'h0);
        check("rst_overflow", 8'(overflow), 8'h0);
        reset = 1'b1;

        for (int i = 0; i < 32; i++) begin
            keys = '0;
            if (vecs[i].kc >= 0) set_key(vecs[i].kc, vecs[i].kr, 1'b1);
            key_ready = vecs[i].rdy;
            do_tick(1'b0);
            check($sformatf("vec%0d_col", i), col_drive, vecs[i].col);
            check($sformatf("vec%0d_valid", i), 8'(key_valid), 8'(vecs[i].vld));
            check($sformatf("vec%0d_held", i), 8'(key_held), 8'(vecs[i].hld));
        end
        check("clean_events", 8'(events), 8'd1);
        check("clean_code", 8'(last_code), 8'h1D);

        // Bounce: two low samples then high -> no event, column moves on.
        goto_col(3);
        set_key(3, 5, 1'b1);
        ticks(2);
        check("bounce_held", 8'(key_held), 8'h0);
        check("bounce_col_hold", col_drive, 8'hF7);
        set_key(3, 5, 1'b0);
        ticks(1);
        check("bounce_col", col_drive, 8'hEF);
        check("bounce_valid", 8'(key_valid), 8'h0);
        check("bounce_events", 8'(events), 8'd1);

        // Priority: rows 2 and 6 in column 1; row 2 wins, row 6 alone is ignored.
        goto_col(1);
        set_key(1, 2, 1'b1);
        set_key(1, 6, 1'b1);
        ticks(4);
        check("prio_valid", 8'(key_valid), 8'h1);
        check("prio_code", 8'(key_code), 8'h0A);
        set_key(1, 2, 1'b0);
        ticks(3);
        check("prio_held_rel", 8'(key_held), 8'h1);
        ticks(1);
        check("prio_held_done", 8'(key_held), 8'h0);
        check("prio_col", col_drive, 8'hFB);
        check("prio_events", 8'(events), 8'd2);
        set_key(1, 6, 1'b0);

        // Backpressure: second press dropped while the first is unconsumed.
        key_ready = 1'b0;
        goto_col(0);
        set_key(0, 0, 1'b1);
        ticks(4);
        check("bp_valid", 8'(key_valid), 8'h1);
        check("bp_code", 8'(key_code), 8'h00);
        set_key(0, 0, 1'b0);
        ticks(4);
        goto_col(7);
        set_key(7, 7, 1'b1);
        ticks(4);
        check("bp_ovf_pulse", 8'(overflow), 8'h1);
        check("bp_code_kept", 8'(key_code), 8'h00);
        check("bp_valid_kept", 8'(key_valid), 8'h1);
        @(negedge clk); #2;
        check("bp_ovf_end", 8'(overflow), 8'h0);
        set_key(7, 7, 1'b0);
        ticks(4);
        check("bp_ovf_count", 8'(ovf_pulses), 8'd1);
        key_ready = 1'b1;
        @(negedge clk); #2;
        check("bp_valid_clr", 8'(key_valid), 8'h0);
        check("bp_events", 8'(events), 8'd3);
        check("bp_last_code", 8'(last_code), 8'h00);

        // Consume and new accept in the same cycle: new code, no overflow.
        key_ready = 1'b0;
        goto_col(2);
        set_key(2, 3, 1'b1);
        ticks(4);
        check("sc_first_code", 8'(key_code), 8'h13);
        set_key(2, 3, 1'b0);
        ticks(4);
        goto_col(5);
        set_key(5, 1, 1'b1);
        ticks(3);
        do_tick(1'b1);
        check("sc_valid", 8'(key_valid), 8'h1);
        check("sc_code", 8'(key_code), 8'h29);
        check("sc_ovf", 8'(overflow), 8'h0);
        check("sc_events", 8'(events), 8'd4);
        check("sc_last_code", 8'(last_code), 8'h13);
        set_key(5, 1, 1'b0);
        ticks(4);

        // Reset during debounce (count=2) with an event still pending.
        set_key(6, 4, 1'b1);
        ticks(2);
        check("rd_col", col_drive, 8'hBF);
        check("rd_pending", 8'(key_valid), 8'h1);
        reset = 1'b0;
        @(negedge clk); #2;
        check("rd_col_rst", col_drive, 8'hFE);
        check("rd_valid_rst", 8'(key_valid), 8'h0);
        check("rd_held_rst", 8'(key_held), 8'h0);
        check("rd_code_rst", 8'(key_code), 8'h00);
        @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        #2;
        check("rd_tick_ignored", col_drive, 8'hFE);
        keys = '0;
        reset = 1'b1;
        key_ready = 1'b1;
        ticks(1);
        check("rd_restart_col", col_drive, 8'hFD);
        ticks(1);
        check("rd_restart_col2", col_drive, 8'hFB);
        check("rd_events", 8'(events), 8'd4);
        check("rd_ovf_total", 8'(ovf_pulses), 8'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
